alu16_reg: RTL and testbench

- 16-bit MIPS-style ALU with registered outputs.
- Per-bit operand conditioning: A invert, B negate. Result multiplexing: AND, OR, XOR, add/sub, set-less-than, less passthrough.
- Sits in the datapath execute stage. Result, carry-out and overflow are captured on the clock edge, so the block has 1-cycle latency.

---
 rtl/alu16_reg.sv | 112 +++++++++++
 tb/tb_alu16_reg.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu16_reg.sv
// 16-bit MIPS-style execute-stage ALU with one cycle of output registering.
// Optional registered zero flag is enabled by defining ALU16_ZERO_FLAG_EN.
module alu16_reg #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             ainvert,
  input  logic             bnegate,
  input  logic             less,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow
`ifdef ALU16_ZERO_FLAG_EN
  ,
  output logic             zero
`endif
);

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b010;
  localparam logic [2:0] OP_XOR  = 3'b110;
  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_SLT  = 3'b011;
  localparam logic [2:0] OP_LESS = 3'b111;

  logic [WIDTH-1:0] a_cond;
  logic [WIDTH-1:0] b_cond;
  logic             carry_in;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
  logic             add_ovf;
  logic             set_lt;

  logic [WIDTH-1:0] result_d, result_q;
  logic             cout_d, cout_q;
  logic             overflow_d, overflow_q;

  // Operand conditioning and shared adder; subtract is ~b with carry-in forced high.
  always_comb begin
    a_cond    = ainvert ? ~a : a;
    b_cond    = bnegate ? ~b : b;
    carry_in  = cin | bnegate;
    sum_ext   = {1'b0, a_cond} + {1'b0, b_cond} + {{WIDTH{1'b0}}, carry_in};
    sum       = sum_ext[WIDTH-1:0];
    carry_out = sum_ext[WIDTH];
    add_ovf   = (a_cond[WIDTH-1] == b_cond[WIDTH-1]) && (sum[WIDTH-1] != a_cond[WIDTH-1]);
    set_lt    = sum[WIDTH-1] ^ add_ovf;
  end

  // Result select; unlisted op codes fall through to all-zero outputs.
  always_comb begin
    result_d   = '0;
    cout_d     = 1'b0;
    overflow_d = 1'b0;
    case (op)
      OP_AND:  result_d = a_cond & b_cond;
      OP_OR:   result_d = a_cond | b_cond;
      OP_XOR:  result_d = a_cond ^ b_cond;
      OP_ADD, OP_SUB: begin
        result_d   = sum;
        cout_d     = carry_out;
        overflow_d = add_ovf;
      end
      OP_SLT: begin
        result_d   = {{(WIDTH-1){1'b0}}, set_lt};
        cout_d     = carry_out;
        overflow_d = add_ovf;
      end
      OP_LESS: result_d = {{(WIDTH-1){1'b0}}, less};
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result_q   <= '0;
      cout_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      result_q   <= result_d;
      cout_q     <= cout_d;
      overflow_q <= overflow_d;
    end
  end

  assign result   = result_q;
  assign cout     = cout_q;
  assign overflow = overflow_q;

`ifdef ALU16_ZERO_FLAG_EN
  logic zero_d, zero_q;

  always_comb begin
    zero_d = (result_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) zero_q <= 1'b0;
    else     zero_q <= zero_d;
  end

  assign zero = zero_q;
`endif

endmodule

// File: tb/tb_alu16_reg.sv
// Self-checking bench for alu16_reg: directed boundary cases plus random ops
// against an arithmetic reference model.
module tb_alu16_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] a, b;
  logic        cin, ainvert, bnegate, less;
  logic [2:0]  op;
  logic [15:0] result;
  logic        cout, overflow;
`ifdef ALU16_ZERO_FLAG_EN
  logic        zero;
`endif

  int checks = 0;
  int errors = 0;

  alu16_reg #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .cin(cin), .ainvert(ainvert),
    .bnegate(bnegate), .less(less), .op(op), .result(result), .cout(cout),
    .overflow(overflow)
`ifdef ALU16_ZERO_FLAG_EN
    , .zero(zero)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "timeout");
  end

  // Reference: {result, cout, overflow} from plain integer arithmetic.
  function automatic logic [17:0] model(input logic [15:0] ia, input logic [15:0] ib,
                                        input logic icin, input logic iainv,
                                        input logic ibneg, input logic iless,
                                        input logic [2:0] iop);
    int unsigned ua, ub, ci, usum;
    int sa, sb, ssum;
    logic [15:0] r;
    logic c, v, set;
    ua   = iainv ? 32'(16'hFFFF - ia) : 32'(ia);
    ub   = ibneg ? 32'(16'hFFFF - ib) : 32'(ib);
    ci   = (icin || ibneg) ? 1 : 0;
    usum = ua + ub + ci;
    sa   = (ua >= 32768) ? int'(ua) - 65536 : int'(ua);
    sb   = (ub >= 32768) ? int'(ub) - 65536 : int'(ub);
    ssum = sa + sb + int'(ci);
    v    = (ssum > 32767) || (ssum < -32768);
    set  = (ssum < 0);
    c    = (usum > 65535);
    r    = 16'h0;
    case (iop)
      3'b000: return {16'(ua & ub), 2'b00};
      3'b010: return {16'(ua | ub), 2'b00};
      3'b110: return {16'(ua ^ ub), 2'b00};
      3'b100, 3'b001: return {16'(usum % 65536), c, v};
      3'b011: begin r = {15'h0, set}; return {r, c, v}; end
      3'b111: begin r = {15'h0, iless}; return {r, 2'b00}; end
      default: return 18'h0;
    endcase
  endfunction

  task automatic set_in(input logic [15:0] ia, input logic [15:0] ib, input logic icin,
                        input logic iainv, input logic ibneg, input logic iless,
                        input logic [2:0] iop);
    a = ia; b = ib; cin = icin; ainvert = iainv; bnegate = ibneg; less = iless; op = iop;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_in(16'h1234, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, 3'b100);
    step();
    step();
    checks++;
    if ({result, cout, overflow} !== 18'h0) begin
      errors++;
      $display("FAIL reset_hold: got %h/%b/%b want 0000/0/0", result, cout, overflow);
    end
`ifdef ALU16_ZERO_FLAG_EN
    checks++;
    if (zero !== 1'b0) begin
      errors++;
      $display("FAIL reset_zero: got %b want 0", zero);
    end
`endif
    rst = 1'b0;
    step();
    checks++;
    if ({result, cout, overflow} !== {16'h1235, 2'b00}) begin
      errors++;
      $display("FAIL reset_release: got %h/%b/%b want 1235/0/0", result, cout, overflow);
    end
    // Reset must win over an operation that would set cout.
    set_in(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, 3'b100);
    rst = 1'b1;
    step();
    checks++;
    if ({result, cout, overflow} !== 18'h0) begin
      errors++;
      $display("FAIL reset_override: got %h/%b/%b want 0000/0/0", result, cout, overflow);
    end
    rst = 1'b0;
  endtask

  task automatic test_logic();
    logic [15:0] ta[5];
    logic [15:0] tb_[5];
    logic [2:0]  top[5];
    logic [15:0] texp[5];
    ta   = '{16'h1, 16'h1, 16'h1, 16'h1, 16'h1};
    tb_  = '{16'h1, 16'h0, 16'h0, 16'h1, 16'h0};
    top  = '{3'b000, 3'b000, 3'b010, 3'b110, 3'b110};
    texp = '{16'h1, 16'h0, 16'h1, 16'h0, 16'h1};
    for (int i = 0; i < 5; i++) begin
      set_in(ta[i], tb_[i], 1'b0, 1'b0, 1'b0, 1'b0, top[i]);
      step();
      checks++;
      if ({result, cout, overflow} !== {texp[i], 2'b00}) begin
        errors++;
        $display("FAIL logic_%0d: got %h/%b/%b want %h/0/0", i, result, cout, overflow, texp[i]);
      end
    end
  endtask

  task automatic test_arith();
    logic [15:0] ta[6];
    logic [15:0] tb_[6];
    logic        tcin[6];
    logic        tbn[6];
    logic [2:0]  top[6];
    logic [17:0] texp[6];
    ta   = '{16'hFFFF, 16'h7FFF, 16'h0001, 16'h0001, 16'h0000, 16'h8000};
    tb_  = '{16'h0001, 16'h0001, 16'h0000, 16'h0000, 16'h0001, 16'h0001};
    tcin = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbn  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    top  = '{3'b100, 3'b100, 3'b100, 3'b001, 3'b001, 3'b001};
    texp = '{{16'h0000, 1'b1, 1'b0}, {16'h8000, 1'b0, 1'b1}, {16'h0002, 1'b0, 1'b0},
             {16'h0001, 1'b1, 1'b0}, {16'hFFFF, 1'b0, 1'b0}, {16'h7FFF, 1'b1, 1'b1}};
    for (int i = 0; i < 6; i++) begin
      set_in(ta[i], tb_[i], tcin[i], 1'b0, tbn[i], 1'b0, top[i]);
      step();
      checks++;
      if ({result, cout, overflow} !== texp[i]) begin
        errors++;
        $display("FAIL arith_%0d: got %h/%b/%b want %h/%b/%b", i, result, cout, overflow,
                 texp[i][17:2], texp[i][1], texp[i][0]);
      end
    end
  endtask

  task automatic test_misc();
    logic [15:0] ta[6];
    logic [15:0] tb_[6];
    logic        tai[6];
    logic        tbn[6];
    logic        tl[6];
    logic [2:0]  top[6];
    logic [15:0] texp[6];
    ta   = '{16'h2, 16'h3, 16'h5, 16'h8000, 16'h0, 16'h1234};
    tb_  = '{16'h1, 16'h5, 16'h3, 16'h1, 16'h0, 16'h5678};
    tai  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbn  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    tl   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    top  = '{3'b000, 3'b011, 3'b011, 3'b011, 3'b111, 3'b101};
    texp = '{16'hFFFC, 16'h1, 16'h0, 16'h1, 16'h1, 16'h0};
    for (int i = 0; i < 6; i++) begin
      set_in(ta[i], tb_[i], 1'b0, tai[i], tbn[i], tl[i], top[i]);
      step();
      checks++;
      if (result !== texp[i]) begin
        errors++;
        $display("FAIL misc_%0d: got %h want %h", i, result, texp[i]);
      end
    end
    // Unused op with every modifier set must still give all zeros.
    set_in(16'hFFFF, 16'hFFFF, 1'b1, 1'b1, 1'b1, 1'b1, 3'b101);
    step();
    checks++;
    if ({result, cout, overflow} !== 18'h0) begin
      errors++;
      $display("FAIL op101_flags: got %h/%b/%b want 0000/0/0", result, cout, overflow);
    end
  endtask

  task automatic test_midcycle();
    logic [17:0] held;
    set_in(16'h0100, 16'h0023, 1'b0, 1'b0, 1'b0, 1'b0, 3'b100);
    step();
    held = {result, cout, overflow};
    checks++;
    if (held !== {16'h0123, 2'b00}) begin
      errors++;
      $display("FAIL midcycle_base: got %h want %h", held, {16'h0123, 2'b00});
    end
    set_in(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, 3'b100);
    #2;
    checks++;
    if ({result, cout, overflow} !== {16'h0123, 2'b00}) begin
      errors++;
      $display("FAIL midcycle_hold: got %h/%b/%b want 0123/0/0", result, cout, overflow);
    end
    step();
    checks++;
    if ({result, cout, overflow} !== {16'h0000, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL midcycle_update: got %h/%b/%b want 0000/1/0", result, cout, overflow);
    end
  endtask

  task automatic test_back_to_back();
    logic [17:0] exp_q[$];
    logic [17:0] exp_v;
    logic [15:0] ra, rb;
    logic        rc, rai, rbn, rl;
    logic [2:0]  rop;
    for (int i = 0; i < 300; i++) begin
      ra  = 16'($urandom);
      rb  = 16'($urandom);
      if (i % 7 == 0) ra = 16'h7FFF;
      if (i % 11 == 0) rb = 16'h8000;
      rc  = 1'($urandom);
      rai = 1'($urandom);
      rbn = 1'($urandom);
      rl  = 1'($urandom);
      rop = 3'($urandom);
      set_in(ra, rb, rc, rai, rbn, rl, rop);
      exp_q.push_back(model(ra, rb, rc, rai, rbn, rl, rop));
      step();
      exp_v = exp_q.pop_front();
      checks++;
      if ({result, cout, overflow} !== exp_v) begin
        errors++;
        $display("FAIL b2b_%0d: op=%b a=%h b=%h got %h/%b/%b want %h/%b/%b", i, rop, ra, rb,
                 result, cout, overflow, exp_v[17:2], exp_v[1], exp_v[0]);
      end
`ifdef ALU16_ZERO_FLAG_EN
      checks++;
      if (zero !== (exp_v[17:2] == 16'h0)) begin
        errors++;
        $display("FAIL b2b_zero_%0d: got %b want %b", i, zero, (exp_v[17:2] == 16'h0));
      end
`endif
    end
  endtask

  initial begin
    rst = 1'b1;
    set_in(16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
    #1;
    test_reset();
    test_logic();
    test_arith();
    test_misc();
    test_midcycle();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
